// File: rtl/fp_operand_unpack_if.sv
// Handshake and operand/decoded-field bundle between the FMA front end
// and its neighbours: raw operands in, per-operand decoded fields out.
interface fp_operand_unpack_if #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_RM   = 3
);
    localparam int W = PARM_EXP + PARM_MANT + 1;

    logic                 In_valid_i;
    logic                 In_ready_o;
    logic [W-1:0]         A_i;
    logic [W-1:0]         B_i;
    logic [W-1:0]         C_i;
    logic                 Sub_i;
    logic [PARM_RM-1:0]   Rounding_mode_i;

    logic                 Out_valid_o;
    logic                 Out_ready_i;

    logic                 A_Sign_o;
    logic [PARM_EXP-1:0]  A_Exp_raw_o;
    logic [PARM_MANT:0]   A_Mant_o;
    logic                 A_DeN_o;
    logic                 A_Zero_o;
    logic                 A_Inf_o;
    logic                 A_NaN_o;
    logic                 A_SNaN_o;

    logic                 B_Sign_o;
    logic [PARM_EXP-1:0]  B_Exp_raw_o;
    logic [PARM_MANT:0]   B_Mant_o;
    logic                 B_DeN_o;
    logic                 B_Zero_o;
    logic                 B_Inf_o;
    logic                 B_NaN_o;
    logic                 B_SNaN_o;

    logic                 C_Sign_o;
    logic [PARM_EXP-1:0]  C_Exp_raw_o;
    logic [PARM_MANT:0]   C_Mant_o;
    logic                 C_DeN_o;
    logic                 C_Zero_o;
    logic                 C_Inf_o;
    logic                 C_NaN_o;
    logic                 C_SNaN_o;

    logic                 Sub_Sign_o;
    logic [PARM_RM-1:0]   Rounding_mode_o;
    logic                 Rm_illegal_o;

    modport master (
        output In_valid_i, A_i, B_i, C_i, Sub_i, Rounding_mode_i,
        output Out_ready_i,
        input  In_ready_o, Out_valid_o,
        input  A_Sign_o, A_Exp_raw_o, A_Mant_o,
        input  A_DeN_o, A_Zero_o, A_Inf_o, A_NaN_o, A_SNaN_o,
        input  B_Sign_o, B_Exp_raw_o, B_Mant_o,
        input  B_DeN_o, B_Zero_o, B_Inf_o, B_NaN_o, B_SNaN_o,
        input  C_Sign_o, C_Exp_raw_o, C_Mant_o,
        input  C_DeN_o, C_Zero_o, C_Inf_o, C_NaN_o, C_SNaN_o,
        input  Sub_Sign_o, Rounding_mode_o, Rm_illegal_o
    );

    modport slave (
        input  In_valid_i, A_i, B_i, C_i, Sub_i, Rounding_mode_i,
        input  Out_ready_i,
        output In_ready_o, Out_valid_o,
        output A_Sign_o, A_Exp_raw_o, A_Mant_o,
        output A_DeN_o, A_Zero_o, A_Inf_o, A_NaN_o, A_SNaN_o,
        output B_Sign_o, B_Exp_raw_o, B_Mant_o,
        output B_DeN_o, B_Zero_o, B_Inf_o, B_NaN_o, B_SNaN_o,
        output C_Sign_o, C_Exp_raw_o, C_Mant_o,
        output C_DeN_o, C_Zero_o, C_Inf_o, C_NaN_o, C_SNaN_o,
        output Sub_Sign_o, Rounding_mode_o, Rm_illegal_o
    );
endinterface

// File: rtl/fp_operand_unpack.sv
// FMA operand unpacker: S1 captures raw operands, S2 holds decoded
// sign/exponent/mantissa/class fields; valid/ready with bubble collapse.
module fp_operand_unpack #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_RM   = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fp_operand_unpack_if.slave bus
);
    localparam int W = PARM_EXP + PARM_MANT + 1;

    typedef struct packed {
        logic                sign;
        logic [PARM_EXP-1:0] expo;
        logic [PARM_MANT:0]  mant;
        logic                den;
        logic                zero;
        logic                inf;
        logic                nan;
        logic                snan;
    } op_dec_t;

    typedef struct packed {
        logic [W-1:0]       a;
        logic [W-1:0]       b;
        logic [W-1:0]       c;
        logic               sub;
        logic [PARM_RM-1:0] rm;
    } s1_t;

    typedef struct packed {
        op_dec_t            a;
        op_dec_t            b;
        op_dec_t            c;
        logic               sub_sign;
        logic [PARM_RM-1:0] rm;
        logic               rm_ill;
    } s2_t;

    function automatic op_dec_t decode(input logic [W-1:0] x);
        logic [PARM_EXP-1:0]  e;
        logic [PARM_MANT-1:0] f;
        logic                 e_zero;
        logic                 e_ones;
        logic                 f_zero;
        op_dec_t              d;
        e      = x[W-2 -: PARM_EXP];
        f      = x[PARM_MANT-1:0];
        e_zero = (e == '0);
        e_ones = &e;
        f_zero = (f == '0);
        d.sign = x[W-1];
        d.expo = e;
        d.mant = {~e_zero, f};
        d.zero = e_zero & f_zero;
        d.den  = e_zero & ~f_zero;
        d.inf  = e_ones & f_zero;
        d.nan  = e_ones & ~f_zero;
        // quiet bit is the fraction MSB; clear means signalling
        d.snan = e_ones & ~f_zero & ~f[PARM_MANT-1];
        return d;
    endfunction

    logic s1_v_q;
    logic s1_v_d;
    logic s2_v_q;
    logic s2_v_d;
    s1_t  s1_q;
    s1_t  s1_d;
    s2_t  s2_q;
    s2_t  s2_d;
    s2_t  s2_next;

    logic in_ready;
    logic s1_load;
    logic s2_load;

    assign in_ready = ~s1_v_q | ~s2_v_q | bus.Out_ready_i;
    assign s1_load  = bus.In_valid_i & in_ready;
    assign s2_load  = s1_v_q & (~s2_v_q | bus.Out_ready_i);

    always_comb begin
        s2_next          = '0;
        s2_next.a        = decode(s1_q.a);
        s2_next.b        = decode(s1_q.b);
        s2_next.c        = decode(s1_q.c);
        s2_next.sub_sign = s1_q.a[W-1] ^ s1_q.b[W-1]
                         ^ s1_q.c[W-1] ^ s1_q.sub;
        s2_next.rm       = s1_q.rm;
        s2_next.rm_ill   = (s1_q.rm > PARM_RM'(4));
    end

    always_comb begin
        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        s2_v_d = s2_v_q;
        s2_d   = s2_q;

        if (s2_load) begin
            s2_v_d = 1'b1;
            s2_d   = s2_next;
        end else if (bus.Out_ready_i) begin
            s2_v_d = 1'b0;
        end

        // S1 may refill in the same cycle it hands its contents to S2
        if (s1_load) begin
            s1_v_d = 1'b1;
            s1_d.a   = bus.A_i;
            s1_d.b   = bus.B_i;
            s1_d.c   = bus.C_i;
            s1_d.sub = bus.Sub_i;
            s1_d.rm  = bus.Rounding_mode_i;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    assign bus.In_ready_o  = in_ready;
    assign bus.Out_valid_o = s2_v_q;

    assign bus.A_Sign_o    = s2_q.a.sign;
    assign bus.A_Exp_raw_o = s2_q.a.expo;
    assign bus.A_Mant_o    = s2_q.a.mant;
    assign bus.A_DeN_o     = s2_q.a.den;
    assign bus.A_Zero_o    = s2_q.a.zero;
    assign bus.A_Inf_o     = s2_q.a.inf;
    assign bus.A_NaN_o     = s2_q.a.nan;
    assign bus.A_SNaN_o    = s2_q.a.snan;

    assign bus.B_Sign_o    = s2_q.b.sign;
    assign bus.B_Exp_raw_o = s2_q.b.expo;
    assign bus.B_Mant_o    = s2_q.b.mant;
    assign bus.B_DeN_o     = s2_q.b.den;
    assign bus.B_Zero_o    = s2_q.b.zero;
    assign bus.B_Inf_o     = s2_q.b.inf;
    assign bus.B_NaN_o     = s2_q.b.nan;
    assign bus.B_SNaN_o    = s2_q.b.snan;

    assign bus.C_Sign_o    = s2_q.c.sign;
    assign bus.C_Exp_raw_o = s2_q.c.expo;
    assign bus.C_Mant_o    = s2_q.c.mant;
    assign bus.C_DeN_o     = s2_q.c.den;
    assign bus.C_Zero_o    = s2_q.c.zero;
    assign bus.C_Inf_o     = s2_q.c.inf;
    assign bus.C_NaN_o     = s2_q.c.nan;
    assign bus.C_SNaN_o    = s2_q.c.snan;

    assign bus.Sub_Sign_o      = s2_q.sub_sign;
    assign bus.Rounding_mode_o = s2_q.rm;
    assign bus.Rm_illegal_o    = s2_q.rm_ill;
endmodule

// File: tb/tb_fp_operand_unpack.sv
// Bench for fp_operand_unpack: directed vectors plus a queue-based
// reference model checked on every output transfer and stall cycle.
module tb_fp_operand_unpack;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_operand_unpack_if bus ();

    fp_operand_unpack dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        sub;
        logic [2:0]  rm;
    } set_t;

    set_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [37:0] model_op(input logic [31:0] x);
        int unsigned mag;
        int unsigned e;
        int unsigned f;
        int unsigned mant;
        logic sign, den, zero, inf, nan, snan;
        mag  = x & 32'h7FFF_FFFF;
        sign = (x >= 32'h8000_0000);
        e    = mag / (2 ** 23);
        f    = mag % (2 ** 23);
        mant = (e != 0) ? f + 2 ** 23 : f;
        zero = (mag == 0);
        den  = (mag > 0) && (mag < 32'h0080_0000);
        inf  = (mag == 32'h7F80_0000);
        nan  = (mag > 32'h7F80_0000);
        snan = nan && (mag < 32'h7FC0_0000);
        return {sign, e[7:0], mant[23:0], den, zero, inf, nan, snan};
    endfunction

    function automatic logic [118:0] model(input set_t s);
        int   nsign;
        logic par;
        logic ill;
        nsign = int'(s.a >> 31) + int'(s.b >> 31)
              + int'(s.c >> 31) + int'(s.sub);
        par = (nsign % 2) == 1;
        ill = (s.rm > 3'd4);
        return {model_op(s.a), model_op(s.b), model_op(s.c),
                par, s.rm, ill};
    endfunction

    function automatic logic [118:0] got_vec();
        return {bus.A_Sign_o, bus.A_Exp_raw_o, bus.A_Mant_o,
                bus.A_DeN_o, bus.A_Zero_o, bus.A_Inf_o,
                bus.A_NaN_o, bus.A_SNaN_o,
                bus.B_Sign_o, bus.B_Exp_raw_o, bus.B_Mant_o,
                bus.B_DeN_o, bus.B_Zero_o, bus.B_Inf_o,
                bus.B_NaN_o, bus.B_SNaN_o,
                bus.C_Sign_o, bus.C_Exp_raw_o, bus.C_Mant_o,
                bus.C_DeN_o, bus.C_Zero_o, bus.C_Inf_o,
                bus.C_NaN_o, bus.C_SNaN_o,
                bus.Sub_Sign_o, bus.Rounding_mode_o, bus.Rm_illegal_o};
    endfunction

    function automatic logic [31:0] a_raw();
        return {bus.A_Sign_o, bus.A_Exp_raw_o, bus.A_Mant_o[22:0]};
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    logic [118:0] snap;
    bit           stalled = 1'b0;
    always @(negedge clk) begin
        set_t s;
        if (rst) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", got_vec(), snap);
            if (bus.Out_valid_o && bus.Out_ready_i) begin
                check("out_has_input", q.size() != 0, 1);
                if (q.size() != 0) begin
                    s = q.pop_front();
                    check("model", got_vec(), model(s));
                end
            end
            stalled = bus.Out_valid_o && !bus.Out_ready_i;
            snap    = got_vec();
            if (bus.In_valid_i && bus.In_ready_o) begin
                s.a   = bus.A_i;
                s.b   = bus.B_i;
                s.c   = bus.C_i;
                s.sub = bus.Sub_i;
                s.rm  = bus.Rounding_mode_i;
                q.push_back(s);
            end
        end
    end

    task automatic drive(input set_t s, input bit v);
        bus.In_valid_i      = v;
        bus.A_i             = s.a;
        bus.B_i             = s.b;
        bus.C_i             = s.c;
        bus.Sub_i           = s.sub;
        bus.Rounding_mode_i = s.rm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present for one accepting edge, then wait for S2 and sample
    task automatic apply_one(input set_t s);
        step();
        bus.Out_ready_i = 1'b1;
        drive(s, 1'b1);
        step();
        drive(s, 1'b0);
        step();
        @(negedge clk);
        check("latency_valid", bus.Out_valid_o, 1);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:23] = 8'h00;
            1: x[30:0]  = 31'h0;
            2: x[30:23] = 8'hFF;
            3: begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
            default: ;
        endcase
        return x;
    endfunction

    function automatic set_t rnd_set();
        set_t s;
        s.a   = rnd_op();
        s.b   = rnd_op();
        s.c   = rnd_op();
        s.sub = 1'($urandom);
        s.rm  = 3'($urandom_range(0, 7));
        return s;
    endfunction

    set_t z;
    set_t t;
    set_t bp[4];
    set_t r;
    int   k;
    int   accepted;
    int   budget;
    bit   found;

    initial begin
        z = '{a: 0, b: 0, c: 0, sub: 0, rm: 0};
        rst = 1'b1;
        bus.Out_ready_i = 1'b0;
        drive(z, 1'b1);
        repeat (2) step();
        rst = 1'b0;
        drive(z, 1'b0);
        @(negedge clk);
        check("rst_out_valid", bus.Out_valid_o, 0);
        check("rst_in_ready", bus.In_ready_o, 1);
        check("rst_outputs", got_vec(), 0);

        t = '{a: 32'h3F80_0000, b: 32'h4000_0000, c: 32'hC040_0000,
              sub: 1'b0, rm: 3'b000};
        apply_one(t);
        check("norm_a_exp", bus.A_Exp_raw_o, 8'h7F);
        check("norm_a_mant", bus.A_Mant_o, 24'h80_0000);
        check("norm_c_sign", bus.C_Sign_o, 1);
        check("norm_flags",
              {bus.A_DeN_o, bus.A_Zero_o, bus.A_Inf_o, bus.A_NaN_o,
               bus.B_DeN_o, bus.B_Zero_o, bus.B_Inf_o, bus.B_NaN_o,
               bus.C_DeN_o, bus.C_Zero_o, bus.C_Inf_o, bus.C_NaN_o,
               bus.A_SNaN_o, bus.B_SNaN_o, bus.C_SNaN_o}, 0);
        check("norm_sub_sign", bus.Sub_Sign_o, 1);

        t = '{a: 32'h0000_0001, b: 32'h7F80_0000, c: 32'h7FA0_0000,
              sub: 1'b0, rm: 3'b001};
        apply_one(t);
        check("spec_a_den", bus.A_DeN_o, 1);
        check("spec_a_mant", bus.A_Mant_o, 24'h00_0001);
        check("spec_a_exp", bus.A_Exp_raw_o, 0);
        check("spec_b_inf", bus.B_Inf_o, 1);
        check("spec_c_nan", bus.C_NaN_o, 1);
        check("spec_c_snan", bus.C_SNaN_o, 1);
        t.c = 32'h7FC0_0000;
        apply_one(t);
        check("qnan_c_nan", bus.C_NaN_o, 1);
        check("qnan_c_snan", bus.C_SNaN_o, 0);

        t.rm = 3'b110;
        apply_one(t);
        check("rm110_illegal", bus.Rm_illegal_o, 1);
        check("rm110_mode", bus.Rounding_mode_o, 3'b110);
        t.rm = 3'b100;
        apply_one(t);
        check("rm100_illegal", bus.Rm_illegal_o, 0);
        check("rm100_mode", bus.Rounding_mode_o, 3'b100);

        for (int i = 0; i < 4; i++) begin
            bp[i].a   = 32'h3F80_0000 + (i << 23) + i;
            bp[i].b   = 32'h8000_0000 | (i << 4);
            bp[i].c   = 32'h4100_0000 + i;
            bp[i].sub = 1'(i);
            bp[i].rm  = 3'(i);
        end
        step();
        bus.Out_ready_i = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            drive(bp[k], 1'b1);
            @(negedge clk);
            if (bus.In_ready_o) k++;
            step();
        end
        check("bp_accepts", k, 2);
        @(negedge clk);
        check("bp_in_ready", bus.In_ready_o, 0);
        check("bp_out_valid", bus.Out_valid_o, 1);
        check("bp_frozen_set1", a_raw(), bp[0].a);
        step();
        bus.Out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (k < 4) drive(bp[k], 1'b1);
            else drive(bp[0], 1'b0);
            @(negedge clk);
            check("bp_order_valid", bus.Out_valid_o, 1);
            check("bp_order", a_raw(), bp[j].a);
            if (bus.In_valid_i && bus.In_ready_o) k++;
            step();
        end

        accepted = 0;
        budget = 0;
        r = rnd_set();
        while (accepted < 1000 && budget < 6000) begin
            drive(r, $urandom_range(0, 9) < 7);
            bus.Out_ready_i = $urandom_range(0, 9) < 6;
            @(negedge clk);
            if (bus.In_valid_i && bus.In_ready_o) begin
                accepted++;
                r = rnd_set();
            end
            step();
            budget++;
        end
        check("rand_accepted", accepted, 1000);
        drive(r, 1'b0);
        bus.Out_ready_i = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        check("rand_drained", q.size(), 0);

        bus.Out_ready_i = 1'b0;
        drive(bp[0], 1'b1);
        step();
        drive(bp[1], 1'b1);
        step();
        rst = 1'b1;
        drive(bp[2], 1'b1);
        step();
        rst = 1'b0;
        drive(bp[2], 1'b0);
        @(negedge clk);
        check("mid_rst_out_valid", bus.Out_valid_o, 0);
        check("mid_rst_in_ready", bus.In_ready_o, 1);
        step();
        bus.Out_ready_i = 1'b1;
        drive(bp[3], 1'b1);
        step();
        drive(bp[3], 1'b0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (bus.Out_valid_o) found = 1'b1;
            else step();
        end
        check("mid_rst_seen", found, 1);
        check("mid_rst_first", a_raw(), bp[3].a);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
